// File: rtl/n8877_media_pkg.sv
// Shared types and constants for the n8877 media-side sector buffer.
package n8877_media_pkg;

  localparam int unsigned SECT_WORDS = 128;
  localparam int unsigned IDX_W      = 7;
  localparam int unsigned TAG_W      = 12;

  localparam logic [7:0]  BUSFREE_DEFAULT   = 8'h00;
  localparam logic [22:0] BASE_ADDR_DEFAULT = 23'h000000;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_FILL = 2'd1,
    MS_NEXT = 2'd2
  } media_state_e;

  // External word address of a sector word; wraps modulo 2^23.
  function automatic logic [22:0] word_addr(input logic [22:0]      base,
                                            input logic [TAG_W-1:0] tag,
                                            input logic [IDX_W-1:0] idx);
    return base + {4'b0000, tag, idx};
  endfunction

endpackage

// File: rtl/n8877_media_ram.sv
// 128x16 simple dual-port sector buffer: synchronous write, registered read.
module n8877_media_ram
  import n8877_media_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [15:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [15:0]      rdata_o
);

  logic [15:0] mem_q [SECT_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/n8877_media.sv
// Media-side responder for the mb8877 fake FDC: serves faddr reads from a local
// sector buffer refilled over a req/ack word bus. Option: N8877_MEDIA_MISS_CNT_EN.
module n8877_media
  import n8877_media_pkg::*;
#(
  parameter logic [22:0] base_addr = BASE_ADDR_DEFAULT,
  parameter logic [7:0]  busfree   = BUSFREE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] faddr,
  input  logic        frd,
  output logic [15:0] frdata,
  output logic [22:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        ready
`ifdef N8877_MEDIA_MISS_CNT_EN
  ,
  output logic [7:0]  miss_cnt
`endif
);

  media_state_e     state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             req_q, req_d;
  logic [22:0]      addr_q, addr_d;
  logic             hit_q;
  logic             hit;
  logic             ram_we;
  logic [15:0]      ram_rdata;
  logic [TAG_W-1:0] sect;

  assign sect = faddr[19:8];
  assign hit  = valid_q && (tag_q == sect);

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    req_d   = req_q;
    ram_we  = 1'b0;
    unique case (state_q)
      MS_IDLE: begin
        if (!hit) begin
          tag_d   = sect;
          valid_d = 1'b0;
          idx_d   = '0;
          req_d   = 1'b1;
          state_d = MS_FILL;
        end
      end
      MS_FILL: begin
        if (mem_ack) begin
          ram_we  = 1'b1;
          req_d   = 1'b0;
          state_d = MS_NEXT;
        end
      end
      MS_NEXT: begin
        // A sector change seen here abandons the partial fill; valid stays low.
        if (sect != tag_q) begin
          tag_d   = sect;
          idx_d   = '0;
          req_d   = 1'b1;
          state_d = MS_FILL;
        end else if (idx_q == IDX_W'(SECT_WORDS - 1)) begin
          valid_d = 1'b1;
          state_d = MS_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          req_d   = 1'b1;
          state_d = MS_FILL;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = MS_IDLE;
      end
    endcase
    addr_d = word_addr(base_addr, tag_d, idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MS_IDLE;
      tag_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      hit_q   <= hit;
    end
  end

  n8877_media_ram u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (idx_q),
    .wdata_i (mem_rdata),
    .raddr_i (faddr[7:1]),
    .rdata_o (ram_rdata)
  );

  // RAM read is already registered; hit_q aligns the valid qualifier with it.
  assign frdata   = hit_q ? ram_rdata : {busfree, busfree};
  assign ready    = hit_q;
  assign mem_req  = req_q;
  assign mem_addr = addr_q;

`ifdef N8877_MEDIA_MISS_CNT_EN
  logic       frd_q;
  logic [7:0] miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frd_q  <= 1'b0;
      miss_q <= '0;
    end else begin
      frd_q <= frd;
      if (frd && !frd_q && !hit && (miss_q != '1)) begin
        miss_q <= miss_q + 8'd1;
      end
    end
  end

  assign miss_cnt = miss_q;

  logic unused_in;
  assign unused_in = faddr[0];
`else
  logic unused_in;
  assign unused_in = ^{frd, faddr[0]};
`endif

endmodule

// File: tb/tb_n8877_media.sv
// Directed self-checking bench for n8877_media with a req/ack memory responder model.
module tb_n8877_media;

  localparam logic [22:0] BASE = 23'h7FFF00;
  localparam logic [7:0]  BF   = 8'h5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] faddr;
  logic        frd;
  logic [15:0] frdata;
  logic [22:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        ready;
`ifdef N8877_MEDIA_MISS_CNT_EN
  logic [7:0]  miss_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int lat      = 1;
  logic [22:0] req_log [$];

  always #5 clk = ~clk;

  n8877_media #(.base_addr(BASE), .busfree(BF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .faddr     (faddr),
    .frd       (frd),
    .frdata    (frdata),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ready     (ready)
`ifdef N8877_MEDIA_MISS_CNT_EN
    ,
    .miss_cnt  (miss_cnt)
`endif
  );

  function automatic logic [22:0] exp_addr(input logic [11:0] tag, input logic [6:0] idx);
    logic [22:0] off;
    off = {4'b0000, tag, idx};
    return BASE + off;
  endfunction

  function automatic logic [15:0] exp_word(input logic [11:0] tag, input logic [6:0] idx);
    logic [18:0] k;
    k = {tag, idx};
    return 16'hA500 + k[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int maxc, output int n);
    n = 0;
    while (ready !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
  endtask

  // Memory: word at address a holds 16'hA500 + (a - BASE); ack 'lat' clocks after req seen.
  initial begin : responder
    logic [22:0] a;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req === 1'b1 && rst_n === 1'b1) begin
        a = mem_addr;
        req_log.push_back(a);
        for (int i = 0; i < lat; i++) begin
          @(posedge clk);
          #1;
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'hA500 + 16'(a - BASE);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    logic seen;
    logic [7:0] bb;

    rst_n = 1'b0;
    faddr = '0;
    frd   = 1'b0;
    #3;
    chk("rst_frdata", frdata, {BF, BF});
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_ready", ready, 0);
    step();
    step();
    req_log.delete();
    rst_n = 1'b1;

    // 1: initial fill of sector 0
    wait_ready(2000, n);
    chk("t1_ready", ready, 1);
    chk("t1_fill_ge384", (n >= 384), 1);
    chk("t1_nreq", req_log.size(), 128);
    chk("t1_first_addr", (req_log.size() > 0) ? req_log[0] : 23'h0, 23'h7FFF00);
    for (int k = 0; k < 128 && k < req_log.size(); k++)
      chk("t1_req_addr", req_log[k], exp_addr(12'h000, 7'(k)));
    faddr = 20'h00003;
    step();
    chk("t1_a501", frdata, 16'hA501);

    // 2: hit reads across the whole sector, no memory traffic
    for (int b = 0; b < 256; b++) begin
      bb    = 8'(b);
      faddr = {12'h000, bb};
      frd   = bb[1];
      step();
      chk("t2_rd", frdata, exp_word(12'h000, bb[7:1]));
      chk("t2_ready", ready, 1);
    end
    frd = 1'b0;
    chk("t2_noreq", req_log.size(), 128);

    // 3: sector change, busfree until refilled, wrapped address
    req_log.delete();
    faddr = 20'h02300;
    step();
    chk("t3_ready_drop", ready, 0);
    chk("t3_busfree0", frdata, {BF, BF});
    n = 0;
    while (ready !== 1'b1 && n < 2000) begin
      chk("t3_busfree", frdata, {BF, BF});
      step();
      n++;
    end
    chk("t3_ready", ready, 1);
    chk("t3_nreq", req_log.size(), 128);
    chk("t3_first_addr", (req_log.size() > 0) ? req_log[0] : 23'h0, 23'h001080);
    for (int k = 0; k < 128 && k < req_log.size(); k++)
      chk("t3_req_addr", req_log[k], exp_addr(12'h023, 7'(k)));
    faddr = 20'h023FF;
    step();
    chk("t3_last_word", frdata, 16'hB6FF);

    // 4: abort at idx 40 with slow ack
    lat = 5;
    req_log.delete();
    faddr = 20'h04500;
    n = 0;
    while (!(mem_req === 1'b1 && mem_addr === exp_addr(12'h045, 7'd40)) && n < 2000) begin
      step();
      n++;
    end
    chk("t4_reach_idx40", mem_addr, exp_addr(12'h045, 7'd40));
    faddr = 20'h06700;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      step();
      n++;
      if (mem_ack === 1'b1) seen = 1'b1;
      else chk("t4_req_held", mem_req, 1);
    end
    chk("t4_ack_seen", seen, 1);
    step();
    chk("t4_next_req_low", mem_req, 0);
    step();
    chk("t4_restart_req", mem_req, 1);
    chk("t4_restart_addr", mem_addr, exp_addr(12'h067, 7'd0));
    wait_ready(5000, n);
    chk("t4_ready", ready, 1);
    chk("t4_nreq", req_log.size(), 169);
    chk("t4_idx40_addr", (req_log.size() > 40) ? req_log[40] : 23'h0, exp_addr(12'h045, 7'd40));
    for (int k = 0; k < 128 && (41 + k) < req_log.size(); k++)
      chk("t4_req_addr", req_log[41 + k], exp_addr(12'h067, 7'(k)));
    lat = 1;
    for (int k = 0; k < 128; k++) begin
      faddr = {12'h067, 7'(k), 1'b0};
      step();
      chk("t4_buf", frdata, exp_word(12'h067, 7'(k)));
    end

    // 5: reset in the middle of a fill
    req_log.delete();
    faddr = 20'h08900;
    n = 0;
    while (!(mem_req === 1'b1 && mem_addr === exp_addr(12'h089, 7'd10)) && n < 2000) begin
      step();
      n++;
    end
    chk("t5_reach_idx10", mem_addr, exp_addr(12'h089, 7'd10));
    rst_n = 1'b0;
    #1;
    chk("t5_req_async", mem_req, 0);
    chk("t5_ready_async", ready, 0);
    chk("t5_frdata_async", frdata, {BF, BF});
    chk("t5_addr_async", mem_addr, 0);
    step();
    step();
    step();
    req_log.delete();
    rst_n = 1'b1;
    wait_ready(2000, n);
    chk("t5_ready", ready, 1);
    chk("t5_nreq", req_log.size(), 128);
    chk("t5_first_addr", (req_log.size() > 0) ? req_log[0] : 23'h0, exp_addr(12'h089, 7'd0));
    chk("t5_last_addr", (req_log.size() > 127) ? req_log[127] : 23'h0, exp_addr(12'h089, 7'd127));
    faddr = 20'h089FE;
    step();
    chk("t5_last_word", frdata, exp_word(12'h089, 7'd127));

`ifdef N8877_MEDIA_MISS_CNT_EN
    // 6: miss counter saturation
    chk("t6_cnt_zero", miss_cnt, 0);
    lat   = 20;
    faddr = 20'h0AB00;
    for (int i = 0; i < 300; i++) begin
      frd = 1'b1;
      step();
      frd = 1'b0;
      step();
      if (i == 9) chk("t6_cnt_10", miss_cnt, 10);
    end
    chk("t6_cnt_sat", miss_cnt, 8'hFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
